// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier for MUL / MLA: result = op_a*op_b (+ op_c), low WIDTH bits.
// Latency: WIDTH cycles from the accept edge to done; with MUL_EARLY_TERM_EN it is max(1, msb(op_b)+1) cycles.
// Backpressure: none; start is taken only in IDLE or DONE and ignored while busy (the controller stalls on busy).
module mul_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             acc_en,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] op_c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_sum;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last;

  // Partial-product add for this iteration and terminal-iteration detect.
  always_comb begin
    acc_sum = mplier[0] ? (acc + mcand) : acc;
`ifdef MUL_EARLY_TERM_EN
    // No remaining multiplier bits after this shift means the sum is already final.
    last = (cnt == CNT_LAST) || ((mplier >> 1) == '0);
`else
    last = (cnt == CNT_LAST);
`endif
  end

  // Next-state logic; a start in DONE re-enters RUN without passing through IDLE.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register with registered busy/done decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

  // Operand capture on accept, one shift-add step per RUN edge, result/flags loaded on the final step.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
      flags  <= 2'b01;
    end else if (accept) begin
      acc    <= acc_en ? op_c : '0;
      mcand  <= op_a;
      mplier <= op_b;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (last) begin
        result <= acc_sum;
        flags  <= {acc_sum[WIDTH-1], (acc_sum == '0)};
      end
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: vector table plus model-driven random ops, checked through a scoreboard queue.
// Hand-written sequences cover start-while-busy, back-to-back start in DONE, reset mid-op and reset+start.
module tb_mul_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        acc_en = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [31:0] op_c = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  flags;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ae;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] res;
    logic [1:0]  fl;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [1:0]  fl;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_res = '0;
  logic [1:0]  last_flags = 2'b01;

  mul_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .acc_en (acc_en),
    .op_a   (op_a),
    .op_b   (op_b),
    .op_c   (op_c),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flags  (flags)
  );

  always #5 clk = ~clk;

  function automatic int model_lat(input logic [31:0] b);
    int h;
    h = 0;
`ifdef MUL_EARLY_TERM_EN
    for (int i = 0; i < 32; i++) if (b[i]) h = i + 1;
    if (h < 1) h = 1;
`else
    h = 32;
`endif
    return h;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Called #1 after a clock edge; leaves the bench #1 after the accept edge.
  task automatic start_op(input logic ae, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] er, input logic [1:0] ef);
    exp_t e;
    acc_en = ae; op_a = a; op_b = b; op_c = c; start = 1'b1;
    e.res = er; e.fl = ef; e.lat = model_lat(b);
    sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for done, holding junk start requests for the first 'noise' cycles.
  task automatic finish_op(input string name, input int noise, input bit b2b);
    exp_t e;
    int   n;
    bit   seen, busy_ok, hold_ok;
    busy_ok = busy;
    hold_ok = 1'b1;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 200) begin
      start = (n < noise);
      if (n < noise) begin
        op_a = 32'd9; op_b = 32'd9; op_c = 32'd5; acc_en = 1'b1;
      end
      @(posedge clk); #1;
      n++;
      if (done) seen = 1'b1;
      else begin
        if (!busy) busy_ok = 1'b0;
        if (result !== last_res || flags !== last_flags) hold_ok = 1'b0;
      end
    end
    start = 1'b0;
    chk({name, " busy_in_run"}, 32'(busy_ok), 32'd1);
    chk({name, " result_held"}, 32'(hold_ok), 32'd1);
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s done_timeout got=no_done exp=done", name);
      void'(sb_q.pop_front());
    end else begin
      e = sb_q.pop_front();
      chk({name, " result"}, result, e.res);
      chk({name, " flags"}, 32'(flags), 32'(e.fl));
      chk({name, " latency"}, 32'(n), 32'(e.lat));
      chk({name, " busy_at_done"}, 32'(busy), 32'd0);
      last_res = e.res;
      last_flags = e.fl;
      if (!b2b) begin
        @(posedge clk); #1;
        chk({name, " done_pulse"}, 32'(done), 32'd0);
      end
    end
  endtask

  initial begin
    vec_t        tbl[7];
    logic [31:0] a, b, c, r;
    logic        ae;
    int          w;
    bit          stray;

    tbl[0] = '{1'b0, 32'd3,          32'd5,          32'd0,   32'd15,         2'b00};
    tbl[1] = '{1'b1, 32'd7,          32'd6,          32'd100, 32'h0000_008E,  2'b00};
    tbl[2] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,   32'h0000_0001,  2'b00};
    tbl[3] = '{1'b0, 32'h8000_0000,  32'd2,          32'd0,   32'h0000_0000,  2'b01};
    tbl[4] = '{1'b0, 32'hFFFF_FFFF,  32'd2,          32'd0,   32'hFFFF_FFFE,  2'b10};
    tbl[5] = '{1'b0, 32'd4,          32'd5,          32'd0,   32'd20,         2'b00};
    tbl[6] = '{1'b1, 32'd123,        32'd0,          32'd7,   32'd7,          2'b00};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst flags", 32'(flags), 32'b01);
    reset = 1'b0;
    @(posedge clk); #1;

    // Table vectors
    for (int i = 0; i < 7; i++) begin
      start_op(tbl[i].ae, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].res, tbl[i].fl);
      finish_op($sformatf("vec%0d", i), 0, 1'b0);
    end

    // Random operands against an arithmetic model
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom; c = $urandom; ae = 1'(i % 2);
      r = a * b + (ae ? c : 32'd0);
      start_op(ae, a, b, c, r, {r[31], (r == 32'd0)});
      finish_op($sformatf("rnd%0d", i), 0, 1'b0);
    end

    // start held during RUN with other operands must be ignored
    start_op(1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 2'b00);
    w = sb_q[0].lat - 1;
    if (w > 5) w = 5;
    finish_op("ignore", w, 1'b0);

    // start in the DONE cycle is accepted with no IDLE cycle in between
    start_op(1'b1, 32'd7, 32'd6, 32'd100, 32'd142, 2'b00);
    finish_op("b2b_first", 0, 1'b1);
    start_op(1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFE, 2'b10);
    finish_op("b2b_second", 0, 1'b0);

    // Reset mid-operation discards the op and clears outputs
    start_op(1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 2'b00);
    w = (sb_q[0].lat > 10) ? 9 : sb_q[0].lat - 1;
    repeat (w) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb_q.delete();
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst result", result, 32'd0);
    chk("midrst flags", 32'(flags), 32'b01);
    last_res = '0;
    last_flags = 2'b01;
    stray = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) stray = 1'b1;
    end
    chk("midrst no_done", 32'(stray), 32'd0);

    // reset and start together: reset wins, request dropped
    acc_en = 1'b0; op_a = 32'd3; op_b = 32'd5;
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    chk("rst_start busy0", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("rst_start busy1", 32'(busy), 32'd0);
    chk("rst_start done", 32'(done), 32'd0);

    // Unit still works after that
    start_op(1'b0, 32'd4, 32'd5, 32'd0, 32'd20, 2'b00);
    finish_op("post_rst", 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
